// File: rtl/div255_pkg.sv
// Shared constants and the stage payload for the divide-by-255 pipeline.
package div255_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_W   = 8;
    localparam int N_STAGES = 4;

    localparam logic [WORD_W-1:0] INV255   = 32'hFEFEFEFF;
    localparam logic [WORD_W-1:0] MAX_QUOT = 32'h01010101;

    // What one stage hands to the next: x bytes still to be consumed, the
    // quotient bytes built so far, the last quotient byte and its borrow.
    typedef struct packed {
        logic [WORD_W-1:0] x_rem;
        logic [WORD_W-1:0] y_part;
        logic [BYTE_W-1:0] y_prev;
        logic              borrow;
        logic              valid;
    } stage_t;

endpackage

// File: rtl/div255_if.sv
// Operand/result bundle between the upstream producer and div255_top.
// The not_mult signal exists only when DIV255_CHECK_EN is defined.
interface div255_if;
    import div255_pkg::*;

    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic              y_valid;
`ifdef DIV255_CHECK_EN
    logic              not_mult;

    modport master (output x, input y, input y_valid, input not_mult);
    modport slave  (input x, output y, output y_valid, output not_mult);
`else
    modport master (output x, input y, input y_valid);
    modport slave  (input x, output y, output y_valid);
`endif

endinterface

// File: rtl/div255_stage.sv
// One byte of the exact-division recurrence y_i = y_(i-1) - x_i - b_(i-1),
// followed by the stage register.
module div255_stage
    import div255_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t i_pl,
    output stage_t o_pl
);

    logic [BYTE_W-1:0] w_x_byte;
    logic [BYTE_W:0]   w_diff;
    stage_t            w_next;
    stage_t            r_pl;

    // Nine-bit subtract: bit 8 is the borrow into the next byte.
    always_comb begin
        w_x_byte = i_pl.x_rem[STAGE*BYTE_W +: BYTE_W];
        w_diff   = {1'b0, i_pl.y_prev} - {1'b0, w_x_byte}
                   - {{BYTE_W{1'b0}}, i_pl.borrow};
        w_next   = i_pl;
        // The consumed x byte is dropped; only the upper bytes travel on.
        w_next.x_rem[STAGE*BYTE_W +: BYTE_W]  = '0;
        w_next.y_part[STAGE*BYTE_W +: BYTE_W] = w_diff[BYTE_W-1:0];
        w_next.y_prev = w_diff[BYTE_W-1:0];
        w_next.borrow = w_diff[BYTE_W];
    end

    // Stage register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pl <= '0;
        end else begin
            r_pl <= w_next;
        end
    end

    assign o_pl = r_pl;

endmodule

// File: rtl/div255_top.sv
// Pipelined exact division by 255: y = x * 0xFEFEFEFF mod 2^32, one byte per
// stage, four stages. The first stage samples x directly, so y_valid rises
// on the fourth consecutive edge with rst low.
// Optional feature macro: DIV255_CHECK_EN adds not_mult.
module div255_top
    import div255_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div255_if.slave  bus
);

    stage_t w_pl [0:N_STAGES];

    // Seed: y_(-1) = 0, b_(-1) = 0; every sampled edge carries a real operand.
    always_comb begin
        w_pl[0]        = '0;
        w_pl[0].x_rem  = bus.x;
        w_pl[0].valid  = 1'b1;
    end

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        div255_stage #(.STAGE(g)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .i_pl (w_pl[g]),
            .o_pl (w_pl[g+1])
        );
    end

    // The final borrow is discarded; the last stage register is the result.
    always_comb begin
        bus.y       = w_pl[N_STAGES].y_part;
        bus.y_valid = w_pl[N_STAGES].valid;
    end

`ifdef DIV255_CHECK_EN
    // Exact quotients never exceed 0x01010101; anything above came from a
    // non-multiple. Compared on the registered y, so no extra latency.
    always_comb begin
        bus.not_mult = w_pl[N_STAGES].valid && (w_pl[N_STAGES].y_part > MAX_QUOT);
    end
`endif

endmodule

// File: tb/tb_div255_top.sv
// Self-checking bench for div255_top: table vectors, latency/reset
// sequences and a randomized run against an operand-queue reference model.
module tb_div255_top;
    import div255_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div255_if bus ();

    div255_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        nm;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: operands in flight, oldest at index N_STAGES-1.
    bit          m_v [N_STAGES];
    logic [31:0] m_x [N_STAGES];

    function automatic logic [31:0] ref_quot(input logic [31:0] a);
        logic [31:0] r;
        r = a * 32'hFEFEFEFF;
        return r;
    endfunction

    function automatic logic ref_nm(input logic [31:0] a);
        return (a % 32'd255) != 32'd0;
    endfunction

    // One clock: update the model at the edge, return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N_STAGES; i++) begin
                m_v[i] = 1'b0;
                m_x[i] = '0;
            end
        end else begin
            for (int i = N_STAGES - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_x[i] = m_x[i-1];
            end
            m_v[0] = 1'b1;
            m_x[0] = bus.x;
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] ey;
        logic        env;
        ey  = m_v[N_STAGES-1] ? ref_quot(m_x[N_STAGES-1]) : 32'd0;
        env = m_v[N_STAGES-1] ? ref_nm(m_x[N_STAGES-1]) : 1'b0;
        chk({tag, " y"}, bus.y, ey);
        chk({tag, " y_valid"}, {31'd0, bus.y_valid}, {31'd0, m_v[N_STAGES-1]});
`ifdef DIV255_CHECK_EN
        chk({tag, " not_mult"}, {31'd0, bus.not_mult}, {31'd0, env});
`else
        if (env === 1'bx) $display("model produced unknown not_mult");
`endif
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{x: 32'd2550,       y: 32'd10,         nm: 1'b0};
        vecs[1] = '{x: 32'd8160,       y: 32'd32,         nm: 1'b0};
        vecs[2] = '{x: 32'd32640,      y: 32'd128,        nm: 1'b0};
        vecs[3] = '{x: 32'd4335,       y: 32'd17,         nm: 1'b0};
        vecs[4] = '{x: 32'd0,          y: 32'd0,          nm: 1'b0};
        vecs[5] = '{x: 32'hFFFFFFFF,   y: 32'h01010101,   nm: 1'b0};
        vecs[6] = '{x: 32'd1,          y: 32'hFEFEFEFF,   nm: 1'b1};
        vecs[7] = '{x: 32'd256,        y: 32'hFEFEFF00,   nm: 1'b1};

        for (int i = 0; i < N_STAGES; i++) begin
            m_v[i] = 1'b0;
            m_x[i] = '0;
        end

        rst   = 1'b1;
        bus.x = 32'd0;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset y", bus.y, 32'd0);
        chk("reset y_valid", {31'd0, bus.y_valid}, 32'd0);
`ifdef DIV255_CHECK_EN
        chk("reset not_mult", {31'd0, bus.not_mult}, 32'd0);
`endif
        rst = 1'b0;

        // Held operands, checked after settling.
        foreach (vecs[i]) begin
            bus.x = vecs[i].x;
            repeat (10) cyc();
            chk($sformatf("vec%0d y", i), bus.y, vecs[i].y);
            chk($sformatf("vec%0d y_valid", i), {31'd0, bus.y_valid}, 32'd1);
`ifdef DIV255_CHECK_EN
            chk($sformatf("vec%0d not_mult", i), {31'd0, bus.not_mult}, {31'd0, vecs[i].nm});
`endif
        end

        // Back-to-back operands: results 1..4 on consecutive cycles.
        bus.x = 32'd255;  cyc();
        bus.x = 32'd510;  cyc();
        bus.x = 32'd765;  cyc();
        chk("lat old result", bus.y, 32'hFEFEFF00);
        bus.x = 32'd1020; cyc();
        chk("lat y1", bus.y, 32'd1);
        bus.x = 32'd0;    cyc();
        chk("lat y2", bus.y, 32'd2);
        cyc();
        chk("lat y3", bus.y, 32'd3);
        cyc();
        chk("lat y4", bus.y, 32'd4);
        chk_model("lat");
        cyc();
        chk("lat y0", bus.y, 32'd0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            bus.x = $urandom;
            cyc();
        end
        rst = 1'b1;
        cyc();
        chk("midrst y", bus.y, 32'd0);
        chk("midrst y_valid", {31'd0, bus.y_valid}, 32'd0);
        cyc();
        chk("midrst2 y_valid", {31'd0, bus.y_valid}, 32'd0);
        rst   = 1'b0;
        bus.x = 32'd510;
        cyc();
        bus.x = 32'd765;
        chk("release e1 y_valid", {31'd0, bus.y_valid}, 32'd0);
        cyc();
        chk("release e2 y_valid", {31'd0, bus.y_valid}, 32'd0);
        cyc();
        chk("release e3 y_valid", {31'd0, bus.y_valid}, 32'd0);
        cyc();
        chk("release e4 y_valid", {31'd0, bus.y_valid}, 32'd1);
        chk("release e4 y", bus.y, 32'd2);

        // Randomized stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       bus.x = 32'd255 * $urandom_range(0, 32'h01010101);
                1:       bus.x = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: bus.x = $urandom;
            endcase
            cyc();
            chk_model($sformatf("rand%0d", i));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
